// File: rtl/slow_clk_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slow_clk_monitor : syncs a slow clock, emits edge strobes, measures its
// period and reports lock / mismatch / timeout status.   Revision 1.0
// ----------------------------------------------------------------------------
module slow_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 4,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch_err,
  output logic             timeout_err
);

  localparam int c_good_w = $clog2(LOCK_COUNT + 1);
  localparam int c_tmo_w  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]     c_exp     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]     c_tol     = (CNT_W+1)'(TOL);
  localparam logic [c_tmo_w-1:0] c_tmo_end = c_tmo_w'(TIMEOUT);
  localparam logic [c_tmo_w-1:0] c_tmo_pre = c_tmo_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     hist_q, hist_d;
  logic                     rise_pulse_q, rise_pulse_d;
  logic                     fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         period_q, period_d;
  logic                     period_valid_q, period_valid_d;
  logic                     locked_q, locked_d;
  logic                     mismatch_err_q, mismatch_err_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [c_good_w-1:0]      good_cnt_q, good_cnt_d;
  logic [c_tmo_w-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic                     w_last;
  logic                     w_rise;
  logic                     w_fall;
  logic [CNT_W:0]           w_diff;
  logic                     w_good;
  logic [c_good_w-1:0]      w_good_inc;
  logic                     w_tmo_evt;
  logic                     w_mm_evt;

  assign w_last = sync_q[SYNC_STAGES-1];
  assign w_rise = w_last & ~hist_q;
  assign w_fall = ~w_last & hist_q;

  // Absolute distance from the expected period, one bit wider to avoid wrap.
  assign w_diff = ({1'b0, cnt_q} >= c_exp) ? ({1'b0, cnt_q} - c_exp)
                                           : (c_exp - {1'b0, cnt_q});
  assign w_good     = (w_diff <= c_tol);
  assign w_good_inc = good_cnt_q + c_good_w'(1);
  // A rise landing on the terminal count restarts the window instead.
  assign w_tmo_evt  = ~w_rise & (tmo_cnt_q == c_tmo_pre);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], slow_in};
    hist_d       = w_last;
    rise_pulse_d = w_rise;
    fall_pulse_d = w_fall;

    if (w_rise)                 cnt_d = CNT_W'(1);
    else if (cnt_q == c_cnt_max) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CNT_W'(1);

    if (w_rise)                  tmo_cnt_d = '0;
    else if (tmo_cnt_q == c_tmo_end) tmo_cnt_d = tmo_cnt_q;
    else                         tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
  end

  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    w_mm_evt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_rise) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (w_good) begin
            good_cnt_d = w_good_inc;
            if (w_good_inc >= c_good_w'(LOCK_COUNT)) begin
              locked_d = 1'b1;
              state_d  = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (w_rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (!w_good) begin
            locked_d   = 1'b0;
            w_mm_evt   = 1'b1;
            good_cnt_d = '0;
            state_d    = MEASURE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase

    if (w_tmo_evt) begin
      state_d    = IDLE;
      locked_d   = 1'b0;
      good_cnt_d = '0;
    end

    // A fresh error event outranks a simultaneous clear.
    mismatch_err_d = (mismatch_err_q & ~err_clr) | w_mm_evt;
    timeout_err_d  = (timeout_err_q  & ~err_clr) | w_tmo_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      hist_q         <= 1'b0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      mismatch_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      good_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      mismatch_err_q <= mismatch_err_d;
      timeout_err_q  <= timeout_err_d;
      good_cnt_q     <= good_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign mismatch_err = mismatch_err_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_slow_clk_monitor : directed self-checking bench for slow_clk_monitor.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_slow_clk_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow_in = 1'b0;
  logic       err_clr = 1'b0;
  logic       rise_pulse, fall_pulse, period_valid, locked, mismatch_err, timeout_err;
  logic [7:0] period;

  int         n_checks = 0;
  int         n_fails  = 0;
  int         n_rise   = 0;
  int         stray_pv = 0;
  int         n0;
  logic       last_pv, last_lock, last_mm;
  logic [7:0] last_per;
  logic [13:0] all_out;

  slow_clk_monitor #(
    .SYNC_STAGES(2), .CNT_W(8), .EXP_PERIOD(4), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .err_clr(err_clr),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .locked(locked),
    .mismatch_err(mismatch_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign all_out = {rise_pulse, fall_pulse, period_valid, locked, mismatch_err, timeout_err, period};

  // One clock: drive slow_in, let the edge happen, then record what a rise showed.
  task automatic step(input logic s);
    slow_in = s;
    @(posedge clk);
    #1;
    if (rise_pulse === 1'b1) begin
      n_rise++;
      last_pv   = period_valid;
      last_per  = period;
      last_lock = locked;
      last_mm   = mismatch_err;
    end
    if (period_valid === 1'b1 && rise_pulse !== 1'b1) stray_pv++;
  endtask

  task automatic run_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      n_checks++;
      if (all_out !== 14'd0) begin n_fails++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    step(1'b1);
    n_checks++; if (rise_pulse !== 1'b0) begin n_fails++; $display("FAIL lat_rise_n: got %b want 0", rise_pulse); end
    step(1'b1);
    n_checks++; if (rise_pulse !== 1'b0) begin n_fails++; $display("FAIL lat_rise_n1: got %b want 0", rise_pulse); end
    step(1'b0);
    n_checks++; if (rise_pulse !== 1'b1) begin n_fails++; $display("FAIL lat_rise_n2: got %b want 1", rise_pulse); end
    n_checks++; if (period_valid !== 1'b0) begin n_fails++; $display("FAIL ref_rise_pv: got %b want 0", period_valid); end
    step(1'b0);
    n_checks++; if (rise_pulse !== 1'b0) begin n_fails++; $display("FAIL lat_rise_width: got %b want 0", rise_pulse); end
    n_checks++; if (fall_pulse !== 1'b0) begin n_fails++; $display("FAIL lat_fall_early: got %b want 0", fall_pulse); end
    step(1'b1);
    n_checks++; if (fall_pulse !== 1'b1) begin n_fails++; $display("FAIL lat_fall: got %b want 1", fall_pulse); end
    step(1'b1);
    n_checks++; if (fall_pulse !== 1'b0) begin n_fails++; $display("FAIL lat_fall_width: got %b want 0", fall_pulse); end
    step(1'b0);
    n_checks++; if (period_valid !== 1'b1) begin n_fails++; $display("FAIL first_pv: got %b want 1", period_valid); end
    n_checks++; if (period !== 8'd4) begin n_fails++; $display("FAIL first_period: got %0d want 4", period); end
    step(1'b0);
  endtask

  task automatic test_lock;
    for (int k = 0; k < 4; k++) begin
      run_period(2, 2);
      n_checks++; if (last_pv !== 1'b1) begin n_fails++; $display("FAIL lock_pv[%0d]: got %b want 1", k, last_pv); end
      n_checks++; if (last_per !== 8'd4) begin n_fails++; $display("FAIL lock_period[%0d]: got %0d want 4", k, last_per); end
      n_checks++; if (last_lock !== (k >= 2)) begin n_fails++; $display("FAIL lock_flag[%0d]: got %b want %b", k, last_lock, (k >= 2)); end
    end
    n_checks++; if (n_rise !== 6) begin n_fails++; $display("FAIL lock_rise_count: got %0d want 6", n_rise); end
    n_checks++; if ({mismatch_err, timeout_err} !== 2'b00) begin n_fails++; $display("FAIL lock_no_err: got %b want 00", {mismatch_err, timeout_err}); end
  endtask

  task automatic test_mismatch;
    run_period(3, 2);
    n_checks++; if (last_lock !== 1'b1 || last_per !== 8'd4) begin n_fails++; $display("FAIL mm_pre: got lock=%b per=%0d want 1/4", last_lock, last_per); end
    run_period(2, 2);
    n_checks++; if (last_per !== 8'd5) begin n_fails++; $display("FAIL mm_period: got %0d want 5", last_per); end
    n_checks++; if (last_lock !== 1'b0) begin n_fails++; $display("FAIL mm_unlock: got %b want 0", last_lock); end
    n_checks++; if (last_mm !== 1'b1) begin n_fails++; $display("FAIL mm_flag: got %b want 1", last_mm); end
    for (int k = 0; k < 4; k++) begin
      run_period(2, 2);
      n_checks++; if (last_lock !== (k == 3)) begin n_fails++; $display("FAIL mm_relock[%0d]: got %b want %b", k, last_lock, (k == 3)); end
    end
    n_checks++; if (mismatch_err !== 1'b1) begin n_fails++; $display("FAIL mm_sticky: got %b want 1", mismatch_err); end
  endtask

  task automatic test_timeout;
    for (int i = 1; i <= 15; i++) begin
      step(1'b0);
      if (i == 14) begin
        n_checks++; if (timeout_err !== 1'b0 || locked !== 1'b1) begin n_fails++; $display("FAIL tmo_early: got tmo=%b lock=%b want 0/1", timeout_err, locked); end
      end
      if (i == 15) begin
        n_checks++; if (timeout_err !== 1'b1) begin n_fails++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
        n_checks++; if (locked !== 1'b0) begin n_fails++; $display("FAIL tmo_unlock: got %b want 0", locked); end
      end
    end
    n0 = n_rise;
    run_period(2, 2);
    n_checks++; if (n_rise !== n0 + 1 || last_pv !== 1'b0) begin n_fails++; $display("FAIL tmo_ref_rise: got rises=%0d pv=%b want %0d/0", n_rise - n0, last_pv, 1); end
    run_period(2, 2);
    n_checks++; if (last_pv !== 1'b1 || last_per !== 8'd4) begin n_fails++; $display("FAIL tmo_restart: got pv=%b per=%0d want 1/4", last_pv, last_per); end
    n_checks++; if ({mismatch_err, timeout_err} !== 2'b11) begin n_fails++; $display("FAIL tmo_both_err: got %b want 11", {mismatch_err, timeout_err}); end
  endtask

  task automatic test_err_clr;
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    n_checks++; if ({mismatch_err, timeout_err} !== 2'b00) begin n_fails++; $display("FAIL clr_both: got %b want 00", {mismatch_err, timeout_err}); end
    step(1'b1); step(1'b0); step(1'b0);
    // Bad period while still measuring must not raise the sticky flag.
    run_period(3, 2);
    run_period(2, 2);
    n_checks++; if (last_per !== 8'd5 || last_mm !== 1'b0 || mismatch_err !== 1'b0) begin n_fails++; $display("FAIL measure_bad_no_flag: got per=%0d mm=%b want 5/0", last_per, mismatch_err); end
    for (int k = 0; k < 4; k++) run_period(2, 2);
    n_checks++; if (locked !== 1'b1) begin n_fails++; $display("FAIL clr_relock: got %b want 1", locked); end
    run_period(3, 2);
    step(1'b1); step(1'b1);
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    n_checks++; if (rise_pulse !== 1'b1 || period !== 8'd5) begin n_fails++; $display("FAIL clr_collide_rise: got rise=%b per=%0d want 1/5", rise_pulse, period); end
    n_checks++; if (mismatch_err !== 1'b1 || locked !== 1'b0) begin n_fails++; $display("FAIL clr_collide_set: got mm=%b lock=%b want 1/0", mismatch_err, locked); end
    step(1'b0);
    n_checks++; if (mismatch_err !== 1'b1 || timeout_err !== 1'b0) begin n_fails++; $display("FAIL clr_collide_hold: got mm=%b tmo=%b want 1/0", mismatch_err, timeout_err); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) run_period(2, 2);
    n_checks++; if (locked !== 1'b1) begin n_fails++; $display("FAIL rm_prelock: got %b want 1", locked); end
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    n_checks++; if (all_out !== 14'd0) begin n_fails++; $display("FAIL rm_outputs: got %h want 0", all_out); end
    step(1'b0); step(1'b0);
    rst = 1'b0;
    n0 = n_rise;
    run_period(2, 2);
    n_checks++; if (n_rise !== n0 + 1 || last_pv !== 1'b0) begin n_fails++; $display("FAIL rm_ref_rise: got rises=%0d pv=%b want 1/0", n_rise - n0, last_pv); end
    for (int k = 0; k < 4; k++) begin
      run_period(2, 2);
      n_checks++; if (last_pv !== 1'b1 || last_lock !== (k == 3)) begin n_fails++; $display("FAIL rm_relock[%0d]: got pv=%b lock=%b want 1/%b", k, last_pv, last_lock, (k == 3)); end
    end
  endtask

  task automatic test_timeout_boundary;
    run_period(8, 8);
    run_period(2, 2);
    n_checks++; if (last_per !== 8'd16 || timeout_err !== 1'b0) begin n_fails++; $display("FAIL tb_rise_wins: got per=%0d tmo=%b want 16/0", last_per, timeout_err); end
    run_period(8, 9);
    n_checks++; if (timeout_err !== 1'b0) begin n_fails++; $display("FAIL tb_tmo_early: got %b want 0", timeout_err); end
    run_period(2, 2);
    n_checks++; if (timeout_err !== 1'b1 || last_pv !== 1'b0) begin n_fails++; $display("FAIL tb_tmo_17: got tmo=%b pv=%b want 1/0", timeout_err, last_pv); end
  endtask

  task automatic test_no_stray_pv;
    n_checks++; if (stray_pv !== 0) begin n_fails++; $display("FAIL stray_period_valid: got %0d want 0", stray_pv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_lock();
    test_mismatch();
    test_timeout();
    test_err_clr();
    test_reset_mid();
    test_timeout_boundary();
    test_no_stray_pv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
